// File: rtl/imem_arbiter_if.sv
`default_nettype none
//==============================================================================
// Module      : imem_arbiter_if
// Description : Two-port fetch request/response bus plus combinational IMEM port.
// Revision    : 1.0 - initial release
//==============================================================================
interface imem_arbiter_if;
   logic [1:0]        req_valid;
   logic [1:0][31:0]  req_addr;
   logic [1:0]        req_ready;
   logic [1:0]        rsp_valid;
   logic [1:0]        rsp_ready;
   logic [31:0]       rsp_data;
   logic              rsp_err;
   logic [31:0]       mem_addr;
   logic [31:0]       mem_data;
   logic              mem_valid;

   modport slave (
      input  req_valid, req_addr, rsp_ready, mem_data, mem_valid,
      output req_ready, rsp_valid, rsp_data, rsp_err, mem_addr
   );

   modport master (
      output req_valid, req_addr, rsp_ready, mem_data, mem_valid,
      input  req_ready, rsp_valid, rsp_data, rsp_err, mem_addr
   );
endinterface
`default_nettype wire

// File: rtl/imem_arbiter.sv
`default_nettype none
//==============================================================================
// Module      : imem_arbiter
// Description : Round-robin two-port arbiter in front of a combinational IMEM.
// Revision    : 1.0 - initial release
//==============================================================================
module imem_arbiter #(
   parameter logic [31:0] NOP_WORD = 32'h00000013,
   parameter int          ERRCNT_W = 16
) (
   input  logic                clock,
   input  logic                reset,
   imem_arbiter_if.slave       bus,
   output logic [ERRCNT_W-1:0] err_count
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RESP = 1'b1
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_owner;
   logic                r_last;
   logic [31:0]         r_rsp_data;
   logic                r_rsp_err;
   logic [ERRCNT_W-1:0] r_err_count;

   logic                w_handshake;
   logic                w_grant;
   logic                w_pick;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Grant is gated by reset so req_ready stays low for the whole reset window.
   always_comb begin
      w_handshake   = 1'b0;
      w_grant       = 1'b0;
      w_pick        = 1'b0;
      w_state_nxt   = r_state;
      bus.req_ready = 2'b00;
      bus.rsp_valid = 2'b00;
      bus.mem_addr  = bus.req_addr[0];

      w_handshake = (r_state == RESP) && bus.rsp_ready[r_owner];

      if (bus.req_valid == 2'b11) begin
         w_pick = ~r_last;
      end else begin
         w_pick = bus.req_valid[1];
      end

      w_grant = !reset && ((r_state == IDLE) || w_handshake) && (bus.req_valid != 2'b00);

      if (w_grant) begin
         bus.req_ready[w_pick] = 1'b1;
         bus.mem_addr          = bus.req_addr[w_pick];
      end

      if (r_state == RESP) begin
         bus.rsp_valid[r_owner] = 1'b1;
      end

      if (w_grant) begin
         w_state_nxt = RESP;
      end else if (w_handshake) begin
         w_state_nxt = IDLE;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_owner     <= 1'b0;
         r_last      <= 1'b1;
         r_rsp_data  <= NOP_WORD;
         r_rsp_err   <= 1'b0;
         r_err_count <= '0;
      end else if (w_grant) begin
         r_owner <= w_pick;
         r_last  <= w_pick;
         if (bus.mem_valid) begin
            r_rsp_data <= bus.mem_data;
            r_rsp_err  <= 1'b0;
         end else begin
            r_rsp_data <= NOP_WORD;
            r_rsp_err  <= 1'b1;
            if (!(&r_err_count)) begin
               r_err_count <= r_err_count + {{(ERRCNT_W-1){1'b0}}, 1'b1};
            end
         end
      end
   end

   assign bus.rsp_data = r_rsp_data;
   assign bus.rsp_err  = r_rsp_err;
   assign err_count    = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_imem_arbiter.sv
`default_nettype none
//==============================================================================
// Module      : tb_imem_arbiter
// Description : Directed and random self-checking bench for imem_arbiter.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_imem_arbiter;

   localparam logic [31:0] NOP = 32'h00000013;
   localparam int          CW  = 4;
   localparam int          CMAX = (1 << CW) - 1;

   logic          clock;
   logic          reset;
   logic          mem_ok;
   logic [CW-1:0] err_count;

   imem_arbiter_if bus();

   imem_arbiter #(.NOP_WORD(NOP), .ERRCNT_W(CW)) dut (
      .clock     (clock),
      .reset     (reset),
      .bus       (bus),
      .err_count (err_count)
   );

   initial clock = 1'b0;
   always #10 clock = ~clock;

   function automatic logic [31:0] memf(input logic [31:0] a);
      if (a == 32'h10) return 32'hDEADBEEF;
      return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
   endfunction

   always_comb begin
      bus.mem_data  = memf(bus.mem_addr);
      bus.mem_valid = mem_ok && (bus.mem_addr[1:0] == 2'b00);
   end

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: is a response outstanding, for whom, what it holds.
   bit          m_busy;
   int          m_owner;
   int          m_last;
   logic [31:0] m_data;
   logic        m_err;
   int          m_cnt;

   bit          last_grant;
   int          last_pick;
   logic [1:0]  obs_rr;
   logic [1:0]  obs_rv;
   logic [31:0] obs_data;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_busy  = 0;
      m_owner = 0;
      m_last  = 1;
      m_data  = NOP;
      m_err   = 1'b0;
      m_cnt   = 0;
   endtask

   // Inputs are already set; check mid-cycle, advance model, cross the edge.
   task automatic cycle();
      logic [1:0]  erv, err_rdy;
      logic [31:0] ea, a;
      bit          can, grant, ok;
      int          pick;
      #5;
      erv      = m_busy ? (2'b01 << m_owner) : 2'b00;
      can      = !m_busy || bus.rsp_ready[m_owner];
      grant    = can && (bus.req_valid != 2'b00);
      pick     = (bus.req_valid == 2'b11) ? 1 - m_last : (bus.req_valid[1] ? 1 : 0);
      err_rdy  = grant ? (2'b01 << pick) : 2'b00;
      ea       = grant ? bus.req_addr[pick] : bus.req_addr[0];
      obs_rr   = bus.req_ready;
      obs_rv   = bus.rsp_valid;
      obs_data = bus.rsp_data;
      chk("rsp_valid", {30'd0, bus.rsp_valid}, {30'd0, erv});
      chk("rsp_data", bus.rsp_data, m_data);
      chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, m_err});
      chk("err_count", {{(32-CW){1'b0}}, err_count}, m_cnt);
      chk("req_ready", {30'd0, bus.req_ready}, {30'd0, err_rdy});
      chk("mem_addr", bus.mem_addr, ea);
      last_grant = grant;
      last_pick  = pick;
      if (grant) begin
         a       = bus.req_addr[pick];
         ok      = mem_ok && (a[1:0] == 2'b00);
         m_busy  = 1;
         m_owner = pick;
         m_last  = pick;
         m_data  = ok ? memf(a) : NOP;
         m_err   = !ok;
         if (!ok && m_cnt < CMAX) m_cnt++;
      end else if (m_busy && can) begin
         m_busy = 0;
      end
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset         = 1'b1;
      bus.req_valid = 2'b11;
      #1;
      model_reset();
      chk("rst_req_ready", {30'd0, bus.req_ready}, 32'd0);
      chk("rst_rsp_valid", {30'd0, bus.rsp_valid}, 32'd0);
      chk("rst_rsp_data", bus.rsp_data, NOP);
      chk("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
      chk("rst_err_count", {{(32-CW){1'b0}}, err_count}, 32'd0);
      @(posedge clock);
      #1;
      reset         = 1'b0;
      bus.req_valid = 2'b00;
   endtask

   initial begin
      reset         = 1'b1;
      mem_ok        = 1'b1;
      bus.req_valid = 2'b00;
      bus.req_addr  = '0;
      bus.rsp_ready = 2'b11;
      model_reset();
      do_reset();

      // Single port-0 fetch of a known word
      bus.req_valid = 2'b01;
      bus.req_addr[0] = 32'h10;
      cycle();
      chk("p0_accept", {30'd0, obs_rr}, 32'd1);
      bus.req_valid = 2'b00;
      cycle();
      chk("p0_rsp_valid", {30'd0, obs_rv}, 32'd1);
      chk("p0_rsp_data", obs_data, 32'hDEADBEEF);
      cycle();

      // Both ports continuously: 0,1,0,1 starting from port 0
      do_reset();
      bus.req_valid   = 2'b11;
      bus.req_addr[0] = 32'h100;
      bus.req_addr[1] = 32'h200;
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("rr_seq", {30'd0, obs_rr}, (i % 2 == 0) ? 32'd1 : 32'd2);
      end
      bus.req_valid = 2'b00;
      cycle();

      // Misaligned port-1 fetch yields NOP with error
      do_reset();
      bus.req_valid   = 2'b10;
      bus.req_addr[1] = 32'h2;
      cycle();
      bus.req_valid = 2'b00;
      cycle();
      chk("err_rsp_valid", {30'd0, obs_rv}, 32'd2);
      chk("err_rsp_data", obs_data, 32'h00000013);
      chk("err_count_1", {{(32-CW){1'b0}}, err_count}, 32'd1);
      cycle();

      // Back-pressure on port 0 blocks port 1 until its handshake
      do_reset();
      bus.rsp_ready   = 2'b00;
      bus.req_valid   = 2'b01;
      bus.req_addr[0] = 32'h20;
      cycle();
      bus.req_valid   = 2'b10;
      bus.req_addr[1] = 32'h40;
      bus.rsp_ready   = 2'b10;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("bp_blocked", {30'd0, obs_rr}, 32'd0);
         chk("bp_stable", obs_data, memf(32'h20));
      end
      bus.rsp_ready = 2'b01;
      cycle();
      chk("bp_release", {30'd0, obs_rr}, 32'd2);
      bus.req_valid = 2'b00;
      bus.rsp_ready = 2'b11;
      cycle();
      cycle();

      // Error counter saturation
      do_reset();
      mem_ok          = 1'b0;
      bus.req_valid   = 2'b10;
      bus.req_addr[1] = 32'h8;
      for (int i = 0; i < CMAX + 2; i++) cycle();
      bus.req_valid = 2'b00;
      cycle();
      chk("err_sat", {{(32-CW){1'b0}}, err_count}, CMAX);
      mem_ok = 1'b1;

      // Reset between edges while a response is held
      do_reset();
      bus.rsp_ready   = 2'b00;
      bus.req_valid   = 2'b01;
      bus.req_addr[0] = 32'h30;
      cycle();
      bus.req_valid = 2'b00;
      reset = 1'b1;
      #1;
      chk("mid_rst_rsp_valid", {30'd0, bus.rsp_valid}, 32'd0);
      chk("mid_rst_rsp_data", bus.rsp_data, NOP);
      reset = 1'b0;
      model_reset();
      bus.rsp_ready   = 2'b11;
      bus.req_valid   = 2'b10;
      bus.req_addr[1] = 32'h44;
      cycle();
      chk("post_rst_grant", {30'd0, obs_rr}, 32'd2);
      bus.req_valid = 2'b00;
      cycle();
      chk("post_rst_data", obs_data, memf(32'h44));

      // Random traffic; addresses held while a request is pending
      last_grant = 0;
      for (int i = 0; i < 400; i++) begin
         for (int p = 0; p < 2; p++) begin
            if (!(bus.req_valid[p] && !(last_grant && last_pick == p))) begin
               bus.req_valid[p] = ($urandom_range(0, 3) != 0);
               bus.req_addr[p]  = {$urandom_range(0, 65535), 16'h0} | 32'($urandom_range(0, 255));
            end
         end
         bus.rsp_ready = 2'($urandom_range(0, 3));
         mem_ok        = ($urandom_range(0, 7) != 0);
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
